srt_div_fp32_ctrl: RTL and testbench

Sequencing controller for the FP32 radix-4 SRT divider datapath. It accepts operand pairs on a valid/ready handshake and captures them. It drives the datapath's load, iterate and round strobes over a fixed iteration count, then captures the packed IEEE result. The result is held on a valid/ready output port with a tag. The block sits between the issuing unit and the divider datapath; the datapath itself stays purely combinational plus its remainder and quotient registers.

---
 rtl/srt_div_fp32_ctrl.sv | 171 +++++++++++++++++
 tb/tb_srt_div_fp32_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srt_div_fp32_ctrl.sv
// Sequencing controller for the FP32 radix-4 SRT divider: handshakes operands in, strobes the datapath, holds the result.
// Optional macro SRT_DIV_SPECIAL_BYPASS_EN: classify special operands at accept and answer them without the datapath.
module srt_div_fp32_ctrl #(
  parameter int ITER_COUNT    = 13,
  parameter int DP_RESULT_LAT = 1,
  parameter int TAG_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_dividend,
  input  logic [31:0]      in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      dp_dividend,
  output logic [31:0]      dp_divisor,
  output logic             dp_load,
  output logic             dp_iter_en,
  output logic [3:0]       dp_iter_cnt,
  output logic             dp_round,
  input  logic [31:0]      dp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_quotient,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
    S_ROUND = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] ITER_LAST = 4'(ITER_COUNT - 1);
  localparam logic [3:0] WAIT_LAST = 4'((DP_RESULT_LAT > 0) ? DP_RESULT_LAT - 1 : 0);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      dividend_q, divisor_q, quot_q;
  logic [TAG_W-1:0] tag_q, out_tag_q;
  logic             accept, bypass, enter_done;
  logic [31:0]      bypass_val;

  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

`ifdef SRT_DIV_SPECIAL_BYPASS_EN
  // Returns {is_special, packed result}; denormals count as zero.
  function automatic logic [32:0] classify(input logic [31:0] a, input logic [31:0] b);
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    sgn    = a[31] ^ b[31];
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf))
      return {1'b1, 32'h7FC0_0000};
    else if (b_zero | a_inf)
      return {1'b1, sgn, 8'hFF, 23'd0};
    else if (a_zero | b_inf)
      return {1'b1, sgn, 31'd0};
    else
      return {1'b0, 32'd0};
  endfunction

  assign {bypass, bypass_val} = classify(in_dividend, in_divisor);
`else
  assign bypass     = 1'b0;
  assign bypass_val = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = bypass ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        state_d = S_ITER;
        cnt_d   = 4'd0;
      end
      S_ITER: begin
        if (cnt_q == ITER_LAST) begin
          state_d = S_ROUND;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ROUND: begin
        cnt_d = 4'd0;
        if (DP_RESULT_LAT > 0) begin
          state_d = S_WAIT;
        end else begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d    = S_DONE;
          cnt_d      = 4'd0;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        // Consuming and accepting in the same cycle chains straight into the next op.
        if (out_ready) state_d = accept ? (bypass ? S_DONE : S_LOAD) : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      tag_q      <= '0;
      quot_q     <= 32'd0;
      out_tag_q  <= '0;
    end else begin
      if (accept) begin
        dividend_q <= in_dividend;
        divisor_q  <= in_divisor;
        tag_q      <= in_tag;
      end
      if (accept & bypass) begin
        quot_q    <= bypass_val;
        out_tag_q <= in_tag;
      end else if (enter_done) begin
        quot_q    <= dp_result;
        out_tag_q <= tag_q;
      end
    end
  end

  assign dp_dividend  = dividend_q;
  assign dp_divisor   = divisor_q;
  assign dp_load      = (state_q == S_LOAD);
  assign dp_iter_en   = (state_q == S_ITER);
  assign dp_iter_cnt  = dp_iter_en ? cnt_q : 4'd0;
  assign dp_round     = (state_q == S_ROUND);
  assign out_valid    = (state_q == S_DONE);
  assign out_quotient = quot_q;
  assign out_tag      = out_tag_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_srt_div_fp32_ctrl.sv
// Self-checking bench for srt_div_fp32_ctrl: directed scenarios plus randomized operands against a behavioural model.
module tb_srt_div_fp32_ctrl;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_dividend = 32'd0;
  logic [31:0]      in_divisor = 32'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      dp_dividend, dp_divisor;
  logic             dp_load, dp_iter_en, dp_round;
  logic [3:0]       dp_iter_cnt;
  logic [31:0]      dp_result;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_quotient;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  srt_div_fp32_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .dp_dividend(dp_dividend), .dp_divisor(dp_divisor),
    .dp_load(dp_load), .dp_iter_en(dp_iter_en), .dp_iter_cnt(dp_iter_cnt),
    .dp_round(dp_round), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stand-in datapath: a fixed answer for 6/2, otherwise an arbitrary mix of the operands.
  function automatic logic [31:0] dp_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a ^ {b[7:0], b[31:8]}) + 32'h1357_9BDF;
  endfunction

  // Result valid one cycle after the round strobe; garbage otherwise.
  logic round_q = 1'b0;
  always @(posedge clk) round_q <= dp_round;
  assign dp_result = round_q ? dp_fn(dp_dividend, dp_divisor) : 32'hDEAD_BEEF;

  // Reference: {takes_bypass, expected quotient}.
  function automatic logic [32:0] ref_model(input logic [31:0] a, input logic [31:0] b);
`ifdef SRT_DIV_SPECIAL_BYPASS_EN
    int ca, cb;   // 0 zero, 1 normal, 2 inf, 3 nan
    logic s;
    logic [31:0] qnan, inf_v, zero_v;
    ca = (a[30:23] == 0) ? 0 : (a[30:23] != 255) ? 1 : (a[22:0] != 0) ? 3 : 2;
    cb = (b[30:23] == 0) ? 0 : (b[30:23] != 255) ? 1 : (b[22:0] != 0) ? 3 : 2;
    s = a[31] ^ b[31];
    qnan = 32'h7FC0_0000;
    inf_v = {s, 31'h7F80_0000};
    zero_v = {s, 31'd0};
    if (ca == 3 || cb == 3) return {1'b1, qnan};
    if (cb == 0) return (ca == 0) ? {1'b1, qnan} : {1'b1, inf_v};
    if (cb == 2) return (ca == 2) ? {1'b1, qnan} : {1'b1, zero_v};
    if (ca == 0) return {1'b1, zero_v};
    if (ca == 2) return {1'b1, inf_v};
`endif
    return {1'b0, dp_fn(a, b)};
  endfunction

  // Strobe monitor: one-hot strobes, counter sequence, operand capture.
  logic mon_en = 1'b0;
  int n_load = 0, n_iter = 0, n_round = 0, exp_it = 0;
  logic [31:0] acc_a = 32'd0, acc_b = 32'd0;
  always @(posedge clk) if (in_valid && in_ready) begin
    acc_a <= in_dividend;
    acc_b <= in_divisor;
  end
  always @(negedge clk) if (mon_en) begin
    check_eq("strobe_onehot", 64'($countones({dp_load, dp_iter_en, dp_round}) <= 1), 1);
    if (dp_load) begin
      n_load++;
      exp_it = 0;
      check_eq("dp_dividend", dp_dividend, acc_a);
      check_eq("dp_divisor", dp_divisor, acc_b);
    end
    if (dp_iter_en) begin
      n_iter++;
      check_eq("iter_cnt", dp_iter_cnt, exp_it);
      exp_it++;
    end else begin
      check_eq("iter_cnt_idle", dp_iter_cnt, 0);
    end
    if (dp_round) n_round++;
  end

  task automatic clr_counts();
    n_load = 0; n_iter = 0; n_round = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_quotient"}, out_quotient, 0);
    check_eq({tag, "_out_tag"}, out_tag, 0);
    check_eq({tag, "_dp_dividend"}, dp_dividend, 0);
    check_eq({tag, "_dp_divisor"}, dp_divisor, 0);
    check_eq({tag, "_dp_load"}, dp_load, 0);
    check_eq({tag, "_dp_iter_en"}, dp_iter_en, 0);
    check_eq({tag, "_dp_iter_cnt"}, dp_iter_cnt, 0);
    check_eq({tag, "_dp_round"}, dp_round, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_in_ready"}, in_ready, 1);
  endtask

  // Present an operand pair and return the edge index at which it was accepted.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                       input bit drop, output int acc_e);
    in_dividend = a; in_divisor = b; in_tag = t; in_valid = 1'b1;
    acc_e = -1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk); #1;
        acc_e = edge_n - 1;
        break;
      end
      @(negedge clk);
    end
    if (acc_e < 0) check_eq("accept_timeout", 0, 1);
    @(negedge clk);
    if (drop) in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int rise);
    rise = -1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (out_valid) begin
        rise = edge_n - 1;
        break;
      end
      @(negedge clk);
    end
    if (rise < 0) check_eq("valid_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t, input int hold);
    logic sp;
    logic [31:0] q;
    int acc, rise;
    {sp, q} = ref_model(a, b);
    clr_counts();
    out_ready = (hold == 0);
    issue(a, b, t, 1'b1, acc);
    wait_valid(rise);
    check_eq("latency", rise - acc, sp ? 0 : 16);
    check_eq("quotient", out_quotient, q);
    check_eq("tag", out_tag, t);
    check_eq("busy_done", busy, 1);
    check_eq("n_load", n_load, sp ? 0 : 1);
    check_eq("n_iter", n_iter, sp ? 0 : 13);
    check_eq("n_round", n_round, sp ? 0 : 1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk); #1;
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_quotient", out_quotient, q);
      check_eq("hold_tag", out_tag, t);
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    check_eq("consumed_valid", out_valid, 0);
    check_eq("consumed_busy", busy, 0);
    $display("op tag=%0d a=%08h b=%08h q=%08h lat=%0d hold=%0d", t, a, b, out_quotient, rise - acc, hold);
  endtask

  function automatic logic [31:0] pick_operand();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: return {s, 31'd0};
      1: return {s, 8'hFF, 23'd0};
      2: return {1'b0, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      3: return {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc1, acc2, r1, r2, found;
    logic [31:0] ra, rb;
    // Reset state
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // 6.0 / 2.0
    run_op(32'h40C0_0000, 32'h4000_0000, 4'd5, 0);

    // Held result under backpressure; a second request waits for out_ready
    clr_counts();
    out_ready = 1'b0;
    issue(32'h40C0_0000, 32'h4000_0000, 4'd9, 1'b1, acc1);
    wait_valid(r1);
    check_eq("bp_latency", r1 - acc1, 16);
    in_dividend = 32'h4120_0000; in_divisor = 32'h3FC0_0000; in_tag = 4'd10; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_quotient", out_quotient, 32'h4040_0000);
      check_eq("bp_tag", out_tag, 9);
      check_eq("bp_in_ready", in_ready, 0);
      @(negedge clk); #1;
    end
    check_eq("bp_no_accept", n_load, 1);
    clr_counts();
    out_ready = 1'b1;
    #1 check_eq("bp_in_ready_release", in_ready, 1);
    @(posedge clk); #1;
    acc2 = edge_n - 1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 check_eq("bp_first_consumed", out_valid, 0);
    wait_valid(r2);
    check_eq("bp2_latency", r2 - acc2, 16);
    check_eq("bp2_quotient", out_quotient, dp_fn(32'h4120_0000, 32'h3FC0_0000));
    check_eq("bp2_tag", out_tag, 10);
    check_eq("bp2_n_load", n_load, 1);
    $display("op tag=10 accepted while tag=9 drained, lat=%0d", r2 - acc2);
    @(negedge clk);

    // Back-to-back, tags 3 and 4
    clr_counts();
    out_ready = 1'b1;
    issue(32'h4100_0000, 32'h4080_0000, 4'd3, 1'b0, acc1);
    in_dividend = 32'hC2C8_0000; in_divisor = 32'h40A0_0000; in_tag = 4'd4;
    wait_valid(r1);
    check_eq("b2b1_latency", r1 - acc1, 16);
    check_eq("b2b1_quotient", out_quotient, dp_fn(32'h4100_0000, 32'h4080_0000));
    check_eq("b2b1_tag", out_tag, 3);
    check_eq("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    acc2 = edge_n - 1;
    check_eq("b2b_accept_edge", acc2, r1 + 1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(r2);
    check_eq("b2b2_latency", r2 - acc2, 16);
    check_eq("b2b2_quotient", out_quotient, dp_fn(32'hC2C8_0000, 32'h40A0_0000));
    check_eq("b2b2_tag", out_tag, 4);
    $display("op tag=3 then tag=4 back-to-back, gap=%0d", r2 - r1);
    @(negedge clk);

    // Reset during ITER at count 6
    clr_counts();
    issue(32'h4040_0000, 32'h3F80_0000, 4'd6, 1'b1, acc1);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (dp_iter_en && dp_iter_cnt == 4'd6) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("reach_iter6", found, 1);
    rst = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(32'h4040_0000, 32'h3F80_0000, 4'd7, 0);

    // Special operands (bypass only when the feature is built in)
    run_op(32'h3F80_0000, 32'h0000_0000, 4'd1, 0);
`ifdef SRT_DIV_SPECIAL_BYPASS_EN
    check_eq("div_by_zero_inf", out_quotient, 32'h7F80_0000);
`else
    check_eq("div_by_zero_dp", out_quotient, dp_fn(32'h3F80_0000, 32'h0000_0000));
`endif
    run_op(32'h8000_0000, 32'h0000_0000, 4'd2, 0);
`ifdef SRT_DIV_SPECIAL_BYPASS_EN
    check_eq("zero_by_zero_nan", out_quotient, 32'h7FC0_0000);
`endif

    // Randomized operands and backpressure
    for (int n = 0; n < 24; n++) begin
      ra = pick_operand();
      rb = pick_operand();
      run_op(ra, rb, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
